shared_bus_tdm_mux: RTL and testbench

//  Parametrised time-division multiplexer giving NCPU CPU cores one shared peripheral bus
//  (video RAM, palette, PSG). Fixed round-robin slots of SLOT_LEN SHCLK cycles each.

---
 rtl/shared_bus_tdm_mux.sv | 154 +++++++++++++++
 tb/tb_shared_bus_tdm_mux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_tdm_mux.sv
// ---------------------------------------------------------------------------
// shared_bus_tdm_mux
//
// Time-division multiplexer that lets NCPU CPU cores share one peripheral bus
// (video RAM, palette, PSG). The bus is handed out in fixed round-robin slots
// of SLOT_LEN SHCLK cycles. A frame is always NCPU*SLOT_LEN cycles long,
// whether or not any CPU is enabled.
//
// Each CPU gets one clock pulse per frame on CPCL[i]. The pulse is high for the
// first half of its own slot. Read data returned to a CPU is live during its
// own slot. Outside that slot the CPU sees the value captured on the last cycle
// of its slot.
//
// Optional feature macro: SHARED_BUS_WRGUARD_EN
//   When defined, the shared write strobe is suppressed on the first and last
//   cycle of every slot. On those cycles the address is changing hands.
//
// Ports
//   SHCLK          system clock, all logic on its rising edge
//   RESET          synchronous active-high reset
//   CPEN  [NCPU]   per-CPU enable (clock held low and strobes masked when 0)
//   CPADR/CPODT    shared bus address / write data (owner's values)
//   CPIDT          shared bus read data from the slaves
//   CPRED/CPWRT    shared bus read / write strobes
//   SLOT  [3]      index of the CPU owning the bus this cycle
//   CPCL  [NCPU]   per-CPU clocks
//   CPAD/CPOD      packed per-CPU addresses / write data, CPU i at slice i
//   CPID           packed per-CPU read data
//   CPRD/CPWR      per-CPU read / write strobes
// ---------------------------------------------------------------------------
module shared_bus_tdm_mux #(
    parameter int NCPU     = 2,
    parameter int SLOT_LEN = 4,
    parameter int AW       = 16,
    parameter int DW       = 8
) (
    input  logic               SHCLK,
    input  logic               RESET,
    input  logic [NCPU-1:0]    CPEN,
    output logic [AW-1:0]      CPADR,
    output logic [DW-1:0]      CPODT,
    input  logic [DW-1:0]      CPIDT,
    output logic               CPRED,
    output logic               CPWRT,
    output logic [2:0]         SLOT,
    output logic [NCPU-1:0]    CPCL,
    input  logic [NCPU*AW-1:0] CPAD,
    input  logic [NCPU*DW-1:0] CPOD,
    output logic [NCPU*DW-1:0] CPID,
    input  logic [NCPU-1:0]    CPRD,
    input  logic [NCPU-1:0]    CPWR
);

    localparam int PW   = $clog2(SLOT_LEN);
    localparam int HALF = SLOT_LEN / 2;

    logic [PW-1:0]   phase_r;
    logic [2:0]      slot_r;
    logic [NCPU-1:0] cpcl_r;
    logic [DW-1:0]   latch_r [NCPU];

    logic [PW-1:0]   phase_next_s;
    logic [2:0]      slot_next_s;
    logic            last_phase_s;
    logic [NCPU-1:0] cpcl_next_s;
    logic            wr_window_s;
    logic            own_rd_s;
    logic            own_wr_s;
    logic            own_en_s;

    // Next phase/slot position and the clock value that position implies.
    always_comb begin
        phase_next_s = phase_r + {{(PW-1){1'b0}}, 1'b1};
        last_phase_s = (phase_r == PW'(SLOT_LEN - 1));
        slot_next_s  = slot_r;
        if (last_phase_s) begin
            if (slot_r == 3'(NCPU - 1)) begin
                slot_next_s = 3'd0;
            end else begin
                slot_next_s = slot_r + 3'd1;
            end
        end else begin
            slot_next_s = slot_r;
        end
        // The clock is registered, so it is derived from the position being
        // entered. A CPEN drop therefore pulls a high pulse low one cycle later.
        cpcl_next_s = '0;
        for (int i = 0; i < NCPU; i++) begin
            cpcl_next_s[i] = CPEN[i] & (slot_next_s == 3'(i)) & (phase_next_s < PW'(HALF));
        end
    end

    // Phase/slot counters, CPU clocks and per-CPU read-data latches.
    always_ff @(posedge SHCLK) begin
        if (RESET) begin
            phase_r <= '0;
            slot_r  <= 3'd0;
            cpcl_r  <= '0;
            for (int i = 0; i < NCPU; i++) begin
                latch_r[i] <= {DW{1'b1}};
            end
        end else begin
            phase_r <= phase_next_s;
            slot_r  <= slot_next_s;
            cpcl_r  <= cpcl_next_s;
            // Capture the owner's read data at the end of its slot. A disabled
            // CPU keeps whatever it last held.
            for (int i = 0; i < NCPU; i++) begin
                if (last_phase_s && (slot_r == 3'(i)) && CPEN[i]) begin
                    latch_r[i] <= CPIDT;
                end else begin
                    latch_r[i] <= latch_r[i];
                end
            end
        end
    end

    // Write-strobe window inside a slot.
    always_comb begin
`ifdef SHARED_BUS_WRGUARD_EN
        wr_window_s = (phase_r != {PW{1'b0}}) && !last_phase_s;
`else
        wr_window_s = 1'b1;
`endif
    end

    // Bus mux: the owning CPU's signals go to the bus; read data fans back out.
    always_comb begin
        CPADR    = '0;
        CPODT    = '0;
        own_rd_s = 1'b0;
        own_wr_s = 1'b0;
        own_en_s = 1'b0;
        CPID     = '0;
        for (int i = 0; i < NCPU; i++) begin
            if (slot_r == 3'(i)) begin
                CPADR    = CPAD[i*AW +: AW];
                CPODT    = CPOD[i*DW +: DW];
                own_rd_s = CPRD[i];
                own_wr_s = CPWR[i];
                own_en_s = CPEN[i];
                CPID[i*DW +: DW] = CPIDT;
            end else begin
                CPID[i*DW +: DW] = latch_r[i];
            end
        end
        CPRED = own_rd_s & own_en_s;
        CPWRT = own_wr_s & own_en_s & wr_window_s;
    end

    assign SLOT = slot_r;
    assign CPCL = cpcl_r;

endmodule

// File: tb/tb_shared_bus_tdm_mux.sv
module tb_shared_bus_tdm_mux;

    localparam int NCPU  = 2;
    localparam int SL    = 4;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int FRAME = NCPU * SL;

    logic               SHCLK = 1'b0;
    logic               RESET;
    logic [NCPU-1:0]    CPEN;
    logic [AW-1:0]      CPADR;
    logic [DW-1:0]      CPODT;
    logic [DW-1:0]      CPIDT;
    logic               CPRED;
    logic               CPWRT;
    logic [2:0]         SLOT;
    logic [NCPU-1:0]    CPCL;
    logic [NCPU*AW-1:0] CPAD;
    logic [NCPU*DW-1:0] CPOD;
    logic [NCPU*DW-1:0] CPID;
    logic [NCPU-1:0]    CPRD;
    logic [NCPU-1:0]    CPWR;

    int checks = 0;
    int errors = 0;

    shared_bus_tdm_mux #(.NCPU(NCPU), .SLOT_LEN(SL), .AW(AW), .DW(DW)) dut (
        .SHCLK(SHCLK), .RESET(RESET), .CPEN(CPEN), .CPADR(CPADR), .CPODT(CPODT),
        .CPIDT(CPIDT), .CPRED(CPRED), .CPWRT(CPWRT), .SLOT(SLOT), .CPCL(CPCL),
        .CPAD(CPAD), .CPOD(CPOD), .CPID(CPID), .CPRD(CPRD), .CPWR(CPWR)
    );

    always #5 SHCLK = ~SHCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_t counts cycles since the last reset edge. Phase and owner follow
    // from plain division.
    int              m_t = 0;
    bit              m_valid = 1'b0;
    logic [NCPU-1:0] m_cpcl;
    logic [DW-1:0]   m_lat [NCPU];

    function automatic int ph_of(input int t);
        return t % SL;
    endfunction

    function automatic int sl_of(input int t);
        return (t / SL) % NCPU;
    endfunction

    function automatic bit wr_ok(input int ph);
`ifdef SHARED_BUS_WRGUARD_EN
        return (ph >= 1) && (ph <= SL - 2);
`else
        return (ph >= 0);
`endif
    endfunction

    always @(posedge SHCLK) begin
        if (RESET) begin
            m_t     <= 0;
            m_valid <= 1'b1;
            m_cpcl  <= '0;
            for (int i = 0; i < NCPU; i++) m_lat[i] <= 8'hFF;
        end else if (m_valid) begin
            if (ph_of(m_t) == SL - 1 && CPEN[sl_of(m_t)]) m_lat[sl_of(m_t)] <= CPIDT;
            m_t <= m_t + 1;
            for (int i = 0; i < NCPU; i++)
                m_cpcl[i] <= CPEN[i] && (sl_of(m_t + 1) == i) && (ph_of(m_t + 1) < SL / 2);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge SHCLK) begin
        if (m_valid) begin
            int s;
            logic [NCPU*DW-1:0] exp_id;
            s = sl_of(m_t);
            for (int j = 0; j < NCPU; j++)
                exp_id[j*DW +: DW] = (j == s) ? CPIDT : m_lat[j];
            chk("m_slot",  64'(SLOT),  64'(s));
            chk("m_cpcl",  64'(CPCL),  64'(m_cpcl));
            chk("m_cpadr", 64'(CPADR), 64'(CPAD[s*AW +: AW]));
            chk("m_cpodt", 64'(CPODT), 64'(CPOD[s*DW +: DW]));
            chk("m_cpred", 64'(CPRED), 64'(CPRD[s] & CPEN[s]));
            chk("m_cpwrt", 64'(CPWRT), 64'(CPWR[s] & CPEN[s] & wr_ok(ph_of(m_t))));
            chk("m_cpid",  64'(CPID),  64'(exp_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge SHCLK);
        #1;
    endtask

    task automatic look();
        @(negedge SHCLK);
        #1;
    endtask

    // Advance until the model position modulo the frame equals r.
    task automatic align(input int r);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((m_t % FRAME) != r && n < 4 * FRAME);
        if ((m_t % FRAME) != r) chk("align_timeout", 64'(m_t % FRAME), 64'(r));
    endtask

    logic [2:0]      slot_lit [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [NCPU-1:0] cpcl_lit [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; CPEN = 2'b11; CPIDT = 8'h00;
        CPAD = '0; CPOD = '0; CPRD = '0; CPWR = '0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset values and the first two frames of slot/clock sequence.
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            look();
            if (k == 0) begin
                chk("rst_cpcl", 64'(CPCL), 64'(2'b00));
                chk("rst_slot", 64'(SLOT), 64'(3'd0));
                chk("rst_cpid", 64'(CPID), 64'(16'hFF00));
            end
            if (k >= 8) begin
                chk("lit_slot", 64'(SLOT), 64'(slot_lit[k-8]));
                chk("lit_cpcl", 64'(CPCL), 64'(cpcl_lit[k-8]));
            end
        end

        // CPU0 read captured at end of slot 0, held through slot 1.
        align(0);
        CPAD = 32'h0000_1234; CPRD = 2'b01; CPIDT = 8'h5A;
        look();
        chk("rd_adr", 64'(CPADR), 64'(16'h1234));
        chk("rd_strobe", 64'(CPRED), 64'(1'b1));
        repeat (4) tick();
        CPIDT = 8'hC3; CPRD = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            look();
            chk("rd_hold0", 64'(CPID[7:0]), 64'(8'h5A));
            chk("rd_live1", 64'(CPID[15:8]), 64'(8'hC3));
        end

        // CPU1 write reaches the bus only while it owns the slot.
        CPAD = 32'hD800_0000; CPOD = 16'h7700; CPWR = 2'b10;
        align(0);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            look();
            chk("wr_strobe", 64'(CPWRT), 64'((k >= SL) && wr_ok(k % SL)));
            if (k >= SL) begin
                chk("wr_adr", 64'(CPADR), 64'(16'hD800));
                chk("wr_dat", 64'(CPODT), 64'(8'h77));
            end
        end

        // CPU1 disabled: no clock, no strobes, CPU0 unaffected.
        CPEN = 2'b01; CPRD = 2'b11; CPWR = 2'b11;
        align(0);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            look();
            chk("dis_cpcl1", 64'(CPCL[1]), 64'(1'b0));
            chk("dis_cpcl0", 64'(CPCL[0]), 64'(k < SL / 2));
            chk("dis_rd", 64'(CPRED), 64'(k < SL));
            chk("dis_wr", 64'(CPWRT), 64'((k < SL) && wr_ok(k % SL)));
        end

        // Reset pulsed at slot 1, phase 2.
        CPEN = 2'b11;
        align(SL + 2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        look();
        chk("rp_slot", 64'(SLOT), 64'(3'd0));
        chk("rp_cpcl", 64'(CPCL), 64'(2'b00));
        chk("rp_cpid1", 64'(CPID[15:8]), 64'(8'hFF));

        // Randomised traffic checked cycle by cycle against the model.
        for (int n = 0; n < 800; n++) begin
            tick();
            CPAD  = 32'($urandom);
            CPOD  = 16'($urandom);
            CPIDT = 8'($urandom);
            CPRD  = 2'($urandom);
            CPWR  = 2'($urandom);
            if ($urandom_range(7) == 0) CPEN = 2'($urandom);
            RESET = ($urandom_range(63) == 0);
        end
        tick();
        RESET = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
